// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and sizing for the SmolBoi SPI slave control path.
package spi_pkg;
    localparam int WORD_BITS = 8;
    localparam int CNT_W = 4;
    localparam logic RW_READ = 1'b1;
    typedef enum logic [3:0] {
        IDLE, GET, GOT, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_MEM, DONE
    } state_t;
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: counts SCLK bits of the current byte, saturating at WORD_BITS.
module spi_bit_counter #(
    parameter int WORD_BITS = spi_pkg::WORD_BITS,
    parameter int CNT_W = spi_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);
    logic [CNT_W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && !o_done)
            r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
    assign o_done = (r_count == CNT_W'(WORD_BITS));
endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: sequences address+R/W byte then one data byte read or write.
// Define SPI_BURST_EN to add addr_inc and continue on sequential addresses until CS rises.
module spi_slave_fsm #(
    parameter int WORD_BITS = spi_pkg::WORD_BITS,
    parameter int CNT_W = spi_pkg::CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_posedge,
    input  logic sclk_negedge,
    input  logic cs_con,
    input  logic rw_bit,
    output logic sr_shift,
    output logic sr_load,
    output logic addr_we,
    output logic dm_we,
    output logic miso_buff
`ifdef SPI_BURST_EN
    ,
    output logic addr_inc
`endif
);
    import spi_pkg::*;
`ifdef SPI_BURST_EN
    localparam state_t R_END = READ_WAIT;
    localparam state_t W_END = WRITE_GET;
`else
    localparam state_t R_END = DONE;
    localparam state_t W_END = DONE;
`endif
    state_t r_state, w_next;
    logic [CNT_W-1:0] w_count;
    logic w_done, w_clear;
    logic [CNT_W:0] w_unused;
    assign w_unused = {sclk_negedge, w_count};
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = GET;
            GET:        w_next = w_done ? GOT : GET;
            GOT:        w_next = (rw_bit == RW_READ) ? READ_WAIT : WRITE_GET;
            READ_WAIT:  w_next = READ_LOAD;
            READ_LOAD:  w_next = READ_SHIFT;
            READ_SHIFT: w_next = w_done ? R_END : READ_SHIFT;
            WRITE_GET:  w_next = w_done ? WRITE_MEM : WRITE_GET;
            WRITE_MEM:  w_next = W_END;
            DONE:       w_next = DONE;
            default:    w_next = IDLE;
        endcase
        if (cs_con)
            w_next = IDLE;
        // a full byte ignores further edges so the counter cannot pass WORD_BITS
        sr_shift = (r_state == GET || r_state == WRITE_GET || r_state == READ_SHIFT) &&
                   sclk_posedge && !cs_con && !w_done;
        sr_load = (r_state == READ_LOAD);
        addr_we = (r_state == GOT);
        dm_we = (r_state == WRITE_MEM);
        miso_buff = (r_state == READ_SHIFT);
    end
`ifdef SPI_BURST_EN
    assign addr_inc = (r_state == WRITE_MEM) || (r_state == READ_SHIFT && w_done);
`endif
    // every state change starts the next byte from zero
    assign w_clear = cs_con || (w_next != r_state);
    spi_bit_counter #(.WORD_BITS(WORD_BITS), .CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_inc   (sr_shift),
        .o_count (w_count),
        .o_done  (w_done)
    );
endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: scoreboard bench; expected output pulses are queued by stimulus, popped by a monitor.
module tb_spi_slave_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sp = 1'b0;
    logic sn = 1'b0;
    logic cs = 1'b1;
    logic rw = 1'b0;
    logic sr_shift, sr_load, addr_we, dm_we, miso_buff, addr_inc;
    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    localparam logic [5:0] SH = 6'b100000, LD = 6'b010000, AW = 6'b001000;
    localparam logic [5:0] DM = 6'b000100, MI = 6'b000010, INC = 6'b000001;
`ifdef SPI_BURST_EN
    localparam logic [5:0] BI = INC;
`else
    localparam logic [5:0] BI = 6'b0;
    assign addr_inc = 1'b0;
`endif
    wire [5:0] w_ev = {sr_shift, sr_load, addr_we, dm_we, miso_buff, addr_inc};

    spi_slave_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .sclk_posedge (sp),
        .sclk_negedge (sn),
        .cs_con       (cs),
        .rw_bit       (rw),
        .sr_shift     (sr_shift),
        .sr_load      (sr_load),
        .addr_we      (addr_we),
        .dm_we        (dm_we),
`ifdef SPI_BURST_EN
        .addr_inc     (addr_inc),
`endif
        .miso_buff    (miso_buff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic push(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            sp = 1'b1;
            tick();
            sp = 1'b0;
            if (i != n - 1) repeat (3) tick();
        end
    endtask

    always @(negedge clk) begin
        if (|w_ev[5:2] || w_ev[0]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected event: got %b expected none", w_ev);
            end else begin
                chk("scoreboard", w_ev, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) tick();
        cs = 1'b0;
        sp = 1'b1;
        #1 chk("outputs in reset", w_ev, 6'b0);
        sp = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        // async reset during the 4th address edge
        push(SH, 3);
        edges(3);
        repeat (2) tick();
        sp = 1'b1;
        #2 chk("mealy shift in GET", w_ev, SH);
        reset = 1'b1;
        #1 chk("async reset mid GET", w_ev, 6'b0);
        @(posedge clk);
        #1;
        sp = 1'b0;
        reset = 1'b0;
        tick();
        // read, address 0x55
        rw = 1'b1;
        push(SH, 8);
        push(AW, 1);
        push(LD, 1);
        push(SH | MI, 8);
        if (BI != 6'b0) push(MI | BI, 1);
        edges(8);
        chk("read addr count full", w_ev, 6'b0);
        tick();
        chk("addr_we latency", w_ev, AW);
        tick();
        chk("read wait", w_ev, 6'b0);
        tick();
        chk("read load", w_ev, LD);
        tick();
        chk("read shift miso", w_ev, MI);
        edges(8);
        chk("read last byte state", w_ev, MI | BI);
        tick();
        chk("after read", w_ev, 6'b0);
`ifndef SPI_BURST_EN
        edges(2);
        chk("done ignores sclk", w_ev, 6'b0);
`endif
        cs = 1'b1;
        tick();
        chk("idle after read", w_ev, 6'b0);
        repeat (2) tick();
        // write, address 0x54
        rw = 1'b0;
        cs = 1'b0;
        tick();
        push(SH, 8);
        push(AW, 1);
        push(SH, 8);
        push(DM | BI, 1);
        edges(8);
        tick();
        chk("write addr_we", w_ev, AW);
        tick();
        chk("write get entry", w_ev, 6'b0);
        edges(8);
        chk("write count full", w_ev, 6'b0);
        tick();
        chk("dm_we latency", w_ev, DM | BI);
        tick();
        chk("after write", w_ev, 6'b0);
        cs = 1'b1;
        tick();
        repeat (2) tick();
        // abort after 5 data edges
        cs = 1'b0;
        tick();
        push(SH, 8);
        push(AW, 1);
        push(SH, 5);
        edges(8);
        repeat (2) tick();
        edges(5);
        cs = 1'b1;
        tick();
        chk("abort idle", w_ev, 6'b0);
        repeat (12) tick();
        // sclk edge coincident with cs rising
        cs = 1'b0;
        tick();
        push(SH, 3);
        edges(3);
        repeat (2) tick();
        sp = 1'b1;
        cs = 1'b1;
        #1 chk("cs rise blocks shift", w_ev, 6'b0);
        @(posedge clk);
        #1;
        sp = 1'b0;
        chk("idle after cs rise", w_ev, 6'b0);
        repeat (2) tick();
        // fresh write proves IDLE with count 0
        cs = 1'b0;
        tick();
        push(SH, 8);
        push(AW, 1);
        push(SH, 8);
        push(DM | BI, 1);
        edges(8);
        repeat (2) tick();
        edges(8);
        tick();
        chk("rewrite dm_we", w_ev, DM | BI);
        tick();
        cs = 1'b1;
        tick();
        repeat (2) tick();
`ifdef SPI_BURST_EN
        cs = 1'b0;
        tick();
        push(SH, 8);
        push(AW, 1);
        for (int k = 0; k < 3; k++) begin
            push(SH, 8);
            push(DM | INC, 1);
        end
        edges(8);
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            edges(8);
            tick();
            chk("burst dm_we addr_inc", w_ev, DM | INC);
            tick();
        end
        cs = 1'b1;
        tick();
        chk("burst idle", w_ev, 6'b0);
`endif
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing events: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
